// File: rtl/core_run_sequencer.sv
// Bring-up sequencer for the accelerator core. It holds the core in reset until PLL lock is qualified
// and SPI is idle, re-resets the core on lock loss, and stretches/counts done pulses.
module core_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sr <= '0;
    else          sr <= {sr[STAGES-2:0], d};

  assign q = sr[STAGES-1];
endmodule

module core_run_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_WAIT_CYCLES   = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int LED_STRETCH_CYCLES = 2**22,
  parameter int CNT_WIDTH          = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       chip_select_n,
  input  logic       done_int,
  output logic       core_reset_n,
  output logic       core_ready,
  output logic       done_led,
  output logic       lock_lost,
  output logic [7:0] run_count,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOCK_WAIT  = 3'd1,
    RESET_HOLD = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LW_LAST  = CNT_WIDTH'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RH_LAST  = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LED_LAST = CNT_WIDTH'(LED_STRETCH_CYCLES - 1);

  logic lk, cs;
  state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic run_d, fault_d;
  logic done_q, rise;
  logic [CNT_WIDTH-1:0] stretch_q;

  core_sync #(.STAGES(SYNC_STAGES)) u_sync_lk (
    .clk(clk), .reset_n(reset_n), .d(pll_locked), .q(lk)
  );
  core_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .d(chip_select_n), .q(cs)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  // Next-state; lock loss beats every other condition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:
        if (lk) begin
          state_d = LOCK_WAIT;
          cnt_d   = '0;
        end
      LOCK_WAIT:
        if (!lk) state_d = FAULT;
        else if (cnt_q == LW_LAST) begin
          state_d = RESET_HOLD;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      RESET_HOLD:
        if (!lk) state_d = FAULT;
        else if (cnt_q == RH_LAST) begin
          if (cs) state_d = RUN;
        end else cnt_d = cnt_q + 1'b1;
      RUN:
        if (!lk) state_d = FAULT;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the next state so the registered versions line up with state_q
  always_comb begin
    run_d   = (state_d == RUN);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      core_reset_n <= 1'b0;
      core_ready   <= 1'b0;
      lock_lost    <= 1'b0;
    end else begin
      core_reset_n <= run_d;
      core_ready   <= run_d;
      lock_lost    <= lock_lost | fault_d;
    end

  assign rise = (state_q == RUN) & done_int & ~done_q;

  // Stretch counter is independent of the FSM so the LED completes after a fault
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      done_q    <= 1'b0;
      run_count <= '0;
      done_led  <= 1'b0;
      stretch_q <= '0;
    end else begin
      done_q <= done_int;
      if (rise) begin
        run_count <= run_count + 8'd1;
        done_led  <= 1'b1;
        stretch_q <= LED_LAST;
      end else if (done_led) begin
        if (stretch_q == '0) done_led  <= 1'b0;
        else                 stretch_q <= stretch_q - 1'b1;
      end
    end

  assign state = state_q;
endmodule

// File: tb/tb_core_run_sequencer.sv
// Scoreboarded bench for core_run_sequencer with SYNC=2, LOCK_WAIT=8, HOLD=4, STRETCH=5.
module tb_core_run_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       chip_select_n = 1'b1;
  logic       done_int = 1'b0;
  logic       core_reset_n, core_ready, done_led, lock_lost;
  logic [7:0] run_count;
  logic [2:0] state;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] rc_exp[$];
  logic [7:0] rc_prev = 8'd0;
  logic [7:0] exp_rc = 8'd0;

  core_run_sequencer #(
    .SYNC_STAGES(2), .LOCK_WAIT_CYCLES(8), .RESET_HOLD_CYCLES(4),
    .LED_STRETCH_CYCLES(5), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .chip_select_n(chip_select_n),
    .done_int(done_int), .core_reset_n(core_reset_n), .core_ready(core_ready),
    .done_led(done_led), .lock_lost(lock_lost), .run_count(run_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (state !== s && n < max) begin
      tick(1);
      n++;
    end
    chk(tag, {29'd0, state}, {29'd0, s});
  endtask

  task automatic push_rise();
    exp_rc = exp_rc + 8'd1;
    rc_exp.push_back(exp_rc);
  endtask

  task automatic restart(input logic cs_n);
    @(posedge clk); #2 reset_n = 1'b0;
    tick(2);
    exp_rc = 8'd0;
    reset_n = 1'b1; pll_locked = 1'b1; chip_select_n = cs_n;
  endtask

  // Scoreboard: every run_count change outside reset must match the next queued value
  always @(negedge clk) begin
    if (run_count !== rc_prev) begin
      if (reset_n) begin
        if (rc_exp.size() == 0) chk("rc_spurious", {24'd0, run_count}, {24'd0, rc_prev});
        else                    chk("run_count", {24'd0, run_count}, {24'd0, rc_exp.pop_front()});
      end
      rc_prev = run_count;
    end
  end

  initial begin
    // 1: reset values and bring-up latency
    tick(2);
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_core_ready", core_ready, 0);
    chk("rst_done_led", done_led, 0);
    chk("rst_lock_lost", lock_lost, 0);
    chk("rst_run_count", run_count, 0);
    chk("rst_state", state, 0);
    reset_n = 1'b1; pll_locked = 1'b1; chip_select_n = 1'b1;
    tick(14);
    chk("t1_edge14_core_reset_n", core_reset_n, 0);
    tick(1);
    chk("t1_edge15_core_reset_n", core_reset_n, 1);
    chk("t1_core_ready", core_ready, 1);
    chk("t1_state_run", state, 3);

    // 2: lock drop during LOCK_WAIT, fault, full wait on relock
    restart(1'b1);
    wait_state(3'd1, 10, "t2_reach_lock_wait");
    tick(3);
    pll_locked = 1'b0;
    tick(2);
    chk("t2_cnt5_state", state, 1);
    tick(1);
    chk("t2_fault_state", state, 4);
    chk("t2_fault_core_reset_n", core_reset_n, 0);
    pll_locked = 1'b1;
    tick(1);
    chk("t2_idle_state", state, 0);
    chk("t2_lock_lost", lock_lost, 1);
    tick(1);
    chk("t2_idle2_state", state, 0);
    tick(1);
    chk("t2_relock_state", state, 1);
    tick(11);
    chk("t2_hold_state", state, 2);
    chk("t2_hold_core_reset_n", core_reset_n, 0);
    tick(1);
    chk("t2_run_state", state, 3);
    chk("t2_lock_lost_sticky", lock_lost, 1);

    // 3: SPI busy holds reset
    restart(1'b0);
    tick(15);
    chk("t3_hold_state", state, 2);
    tick(10);
    chk("t3_still_hold", state, 2);
    chk("t3_core_reset_n", core_reset_n, 0);
    chip_select_n = 1'b1;
    tick(2);
    chk("t3_cs_edge2_state", state, 2);
    tick(1);
    chk("t3_cs_edge3_state", state, 3);
    chk("t3_core_reset_n_hi", core_reset_n, 1);

    // 4: three pulses two cycles apart, then a held level
    for (int i = 0; i < 11; i++) begin
      done_int = (i == 0 || i == 2 || i == 4);
      if (done_int) push_rise();
      tick(1);
      chk($sformatf("t4_led_%0d", i), done_led, (i <= 8) ? 1 : 0);
    end
    chk("t4_run_count", run_count, 3);
    done_int = 1'b1;
    push_rise();
    tick(4);
    done_int = 1'b0;
    tick(2);
    chk("t4_level_one_rise", run_count, 4);

    // 5: lock loss in RUN, rise in the same cycle, LED outlives the fault
    pll_locked = 1'b0;
    tick(2);
    chk("t5_lk_fall_state", state, 3);
    chk("t5_lk_fall_core_reset_n", core_reset_n, 1);
    done_int = 1'b1;
    push_rise();
    tick(1);
    chk("t5_fault_state", state, 4);
    chk("t5_fault_core_reset_n", core_reset_n, 0);
    chk("t5_fault_core_ready", core_ready, 0);
    done_int = 1'b0;
    tick(1);
    chk("t5_idle_state", state, 0);
    chk("t5_lock_lost", lock_lost, 1);
    tick(3);
    chk("t5_led_hold", done_led, 1);
    tick(1);
    chk("t5_led_off", done_led, 0);
    chk("t5_run_count_kept", run_count, 5);

    // 6: async reset mid-RUN, then wrap of run_count
    pll_locked = 1'b1;
    wait_state(3'd3, 40, "t6_reach_run");
    done_int = 1'b1;
    push_rise();
    tick(1);
    done_int = 1'b0;
    chk("t6_led_before_rst", done_led, 1);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    chk("t6_async_core_reset_n", core_reset_n, 0);
    chk("t6_async_core_ready", core_ready, 0);
    chk("t6_async_done_led", done_led, 0);
    chk("t6_async_lock_lost", lock_lost, 0);
    chk("t6_async_run_count", run_count, 0);
    chk("t6_async_state", state, 0);
    tick(2);
    exp_rc = 8'd0;
    reset_n = 1'b1;
    wait_state(3'd3, 40, "t6_rerun");
    for (int k = 0; k < 256; k++) begin
      done_int = 1'b1;
      push_rise();
      tick(1);
      done_int = 1'b0;
      tick(1);
      if (k == 254) chk("t6_run_count_255", run_count, 255);
    end
    chk("t6_run_count_wrap", run_count, 0);
    tick(2);
    chk("sb_empty", rc_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
